// File: rtl/frame_cfg_sched_if.sv
// Host configuration channel for frame_cfg_sched: valid/ready request
// carrying (M, SS), plus a one-cycle error pulse for discarded requests.
interface frame_cfg_sched_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_m;
    logic [3:0] cfg_ss;
    logic       cfg_err;

    modport master (
        output cfg_valid, cfg_m, cfg_ss,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_m, cfg_ss,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/frame_cfg_sched.sv
// Frame scheduler and modulation/spreading config sequencer.
// After a warm-up, emits a periodic sof_tx strobe while enabled. Host config
// requests land in a single pending slot and are applied to the tx indices on
// the next sof_tx. Every sof_tx records the frame's effective tx config in a
// small FIFO; the rx indices pop from it on each sof_rx so the rx path follows
// the tx frame history.
module frame_cfg_sched #(
    parameter int FRAME_LEN = 1024,
    parameter int WARMUP    = 100,
    parameter int DEPTH     = 4,
    parameter int M_MAX     = 5,
    parameter int SS_MAX    = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_i,        // async, active low
    input  logic                     en_i,
    input  logic                     sof_rx_i,
    frame_cfg_sched_if.slave         cfg,
    output logic                     sof_tx_o,
    output logic [15:0]              frame_cnt_o,
    output logic [2:0]               index_M_tx_o,
    output logic [3:0]               index_SS_tx_o,
    output logic [2:0]               index_M_rx_o,
    output logic [3:0]               index_SS_rx_o,
    output logic [$clog2(DEPTH):0]   fifo_lvl_o,
    output logic                     ready_o,
    output logic                     ovf_o,
    output logic                     unf_o
);

    localparam int PH_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int WU_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FRAME_LEN - 1);
    localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP - 1);

    typedef enum logic [1:0] {S_WARMUP, S_IDLE, S_RUN} state_t;

    typedef struct packed {
        logic [2:0] m;
        logic [3:0] ss;
    } cfg_t;

    localparam cfg_t CFG_RST = '{m: 3'd1, ss: 4'd1};

    state_t          state_q, state_d;
    logic [WU_W-1:0] wu_q, wu_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic            pend_vld_q, pend_vld_d;
    cfg_t            pend_q, pend_d;
    cfg_t            tx_q, tx_d;
    cfg_t            rx_q, rx_d;
    logic            cfg_err_q, cfg_err_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    cfg_t            mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   lvl_q, lvl_d;

    logic            sof_tx, ready, cfg_ready;
    logic            wu_last, ph_last;
    logic            accept, legal;
    logic            full, empty, push, pop;
    cfg_t            eff_cfg;

    assign wu_last = (wu_q == WU_LAST);
    assign ph_last = (phase_q == PH_LAST);

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_WARMUP;
        else        state_q <= state_d;
    end

    // FSM: next state; a disabled RUN always finishes the current frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WARMUP: if (wu_last)           state_d = S_IDLE;
            S_IDLE:   if (en_i)              state_d = S_RUN;
            S_RUN:    if (!en_i && ph_last)  state_d = S_IDLE;
            default:                         state_d = S_WARMUP;
        endcase
    end

    // FSM: outputs decoded from state and frame phase
    always_comb begin
        sof_tx    = (state_q == S_RUN) && (phase_q == '0);
        ready     = (state_q != S_WARMUP);
        cfg_ready = ready && !pend_vld_q;
    end

    // Warm-up counter, frame phase and frame counter next-state
    always_comb begin
        wu_d        = wu_q;
        phase_d     = '0;
        frame_cnt_d = frame_cnt_q;
        if (state_q == S_WARMUP && !wu_last) wu_d = wu_q + 1'b1;
        if (state_q == S_RUN)                phase_d = ph_last ? '0 : phase_q + 1'b1;
        if (sof_tx)                          frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wu_q        <= '0;
            phase_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            wu_q        <= wu_d;
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign accept = cfg.cfg_valid && cfg_ready;
    assign legal  = (cfg.cfg_m  != '0) && (32'(cfg.cfg_m)  <= M_MAX) &&
                    (cfg.cfg_ss != '0) && (32'(cfg.cfg_ss) <= SS_MAX);

    // The value pushed for a frame is what tx will use for it, i.e. after
    // the pending slot (if any) has been applied at this sof_tx.
    assign eff_cfg = pend_vld_q ? pend_q : tx_q;

    assign full  = (lvl_q == LW'(DEPTH));
    assign empty = (lvl_q == '0);
    assign push  = sof_tx && !full;
    assign pop   = sof_rx_i && ready && !empty;

    // Config slot, tx/rx indices, FIFO pointers and sticky flags next-state.
    // Accepts never coincide with an apply: cfg_ready is low while pending.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cfg_err_d  = accept && !legal;
        ovf_d      = ovf_q || (sof_tx && full);
        unf_d      = unf_q || (sof_rx_i && ready && empty);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        lvl_d      = lvl_q;

        if (sof_tx && pend_vld_q) begin
            tx_d       = pend_q;
            pend_vld_d = 1'b0;
        end else if (accept && legal) begin
            pend_d     = '{m: cfg.cfg_m, ss: cfg.cfg_ss};
            pend_vld_d = 1'b1;
        end

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop) begin
            rx_d   = mem_q[rptr_q];
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    // Config, index, FIFO-control and flag registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_vld_q <= 1'b0;
            pend_q     <= CFG_RST;
            tx_q       <= CFG_RST;
            rx_q       <= CFG_RST;
            cfg_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            lvl_q      <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cfg_err_q  <= cfg_err_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lvl_q      <= lvl_d;
        end
    end

    // FIFO storage; contents are only meaningful below the level count
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= eff_cfg;
    end

    assign cfg.cfg_ready = cfg_ready;
    assign cfg.cfg_err   = cfg_err_q;
    assign sof_tx_o      = sof_tx;
    assign ready_o       = ready;
    assign frame_cnt_o   = frame_cnt_q;
    assign index_M_tx_o  = tx_q.m;
    assign index_SS_tx_o = tx_q.ss;
    assign index_M_rx_o  = rx_q.m;
    assign index_SS_rx_o = rx_q.ss;
    assign fifo_lvl_o    = lvl_q;
    assign ovf_o         = ovf_q;
    assign unf_o         = unf_q;

endmodule
